// File: rtl/floor_request_scheduler.sv
// ============================================================================
// Module   : floor_request_scheduler
// Purpose  : Pending-floor bitmap with LOOK-policy direction recommendation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floor_request_scheduler #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  current_up_ndown,
    input  logic                  deassert_floor,
    output logic [NUM_FLOORS-1:0] queue_status,
    output logic                  queue_empty,
    output logic                  next_up_ndown,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  req_error,
    output logic                  door_open
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    localparam logic [FLOOR_W:0] C_NUM_FLOORS = (FLOOR_W+1)'(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic                  req_error_q, req_error_d;
    logic                  door_open_q, door_open_d;
    logic                  deassert_q, deassert_d;

    logic [FLOOR_W:0]      w_cf_ext;
    logic [FLOOR_W:0]      w_rf_ext;
    logic                  w_cf_valid;
    logic                  w_rf_valid;
    logic                  w_above;
    logic                  w_below;
    logic [FLOOR_W:0]      w_dist_up;
    logic [FLOOR_W:0]      w_dist_dn;
    logic [CNT_W-1:0]      w_count;
    logic                  w_rise;
    logic                  w_at_idle_floor;

    // An out-of-range car position is above every floor, so all pending bits land in "below".
    always_comb begin
        w_cf_ext   = {1'b0, current_floor};
        w_rf_ext   = {1'b0, req_floor};
        w_cf_valid = (w_cf_ext < C_NUM_FLOORS);
        w_rf_valid = (w_rf_ext < C_NUM_FLOORS);
        w_above    = 1'b0;
        w_below    = 1'b0;
        w_dist_up  = '1;
        w_dist_dn  = '1;
        w_count    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_count = w_count + CNT_W'(pend_q[i]);
            if (pend_q[i]) begin
                if ((FLOOR_W+1)'(i) > w_cf_ext) begin
                    w_above = 1'b1;
                    if (((FLOOR_W+1)'(i) - w_cf_ext) < w_dist_up)
                        w_dist_up = (FLOOR_W+1)'(i) - w_cf_ext;
                end else if ((FLOOR_W+1)'(i) < w_cf_ext) begin
                    w_below = 1'b1;
                    if ((w_cf_ext - (FLOOR_W+1)'(i)) < w_dist_dn)
                        w_dist_dn = w_cf_ext - (FLOOR_W+1)'(i);
                end
            end
        end
    end

    always_comb begin
        w_rise          = deassert_floor & ~deassert_q;
        w_at_idle_floor = (req_floor == current_floor) && (pend_q == '0) && (state_q == ST_IDLE);
        req_error_d     = req_valid & ~w_rf_valid;
        door_open_d     = req_valid & w_rf_valid & w_at_idle_floor;
        deassert_d      = deassert_floor;
        pend_d          = pend_q;
        // Clear first so a same-cycle re-request of the floor being served survives.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_rise && w_cf_valid && (w_cf_ext == (FLOOR_W+1)'(i)))
                pend_d[i] = 1'b0;
            if (req_valid && w_rf_valid && !w_at_idle_floor && (w_rf_ext == (FLOOR_W+1)'(i)))
                pend_d[i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            ST_UP: begin
                dir_d = 1'b1;
                if (w_above)      state_d = ST_UP;
                else if (w_below) state_d = ST_DOWN;
                else              state_d = ST_IDLE;
            end
            ST_DOWN: begin
                dir_d = 1'b0;
                if (w_below)      state_d = ST_DOWN;
                else if (w_above) state_d = ST_UP;
                else              state_d = ST_IDLE;
            end
            default: begin
                if (w_above && w_below) begin
                    if (w_dist_up < w_dist_dn)      state_d = ST_UP;
                    else if (w_dist_dn < w_dist_up) state_d = ST_DOWN;
                    else                            state_d = current_up_ndown ? ST_UP : ST_DOWN;
                end else if (w_above) begin
                    state_d = ST_UP;
                end else if (w_below) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= '0;
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            req_error_q <= 1'b0;
            door_open_q <= 1'b0;
            deassert_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            req_error_q <= req_error_d;
            door_open_q <= door_open_d;
            deassert_q  <= deassert_d;
        end
    end

    assign queue_status  = pend_q;
    assign queue_empty   = (pend_q == '0);
    assign pending_count = w_count;
    assign next_up_ndown = dir_q;
    assign req_error     = req_error_q;
    assign door_open     = door_open_q;

endmodule

`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
// ============================================================================
// Module   : tb_floor_request_scheduler
// Purpose  : Directed scenarios plus randomized run against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floor_request_scheduler;

    localparam int N = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = 3'd0;
    logic [2:0] current_floor = 3'd0;
    logic       current_up_ndown = 1'b0;
    logic       deassert_floor = 1'b0;
    logic [6:0] queue_status;
    logic       queue_empty;
    logic       next_up_ndown;
    logic [2:0] pending_count;
    logic       req_error;
    logic       door_open;

    int total = 0;
    int bad   = 0;

    // Reference model: set of pending floors and direction mode (0 idle, 1 up, 2 down)
    bit m_pend [N];
    int m_mode = 0;
    bit m_dir  = 0;
    bit m_err  = 0;
    bit m_door = 0;
    bit m_deq  = 0;

    floor_request_scheduler #(.NUM_FLOORS(7), .FLOOR_W(3), .CNT_W(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_floor        (req_floor),
        .current_floor    (current_floor),
        .current_up_ndown (current_up_ndown),
        .deassert_floor   (deassert_floor),
        .queue_status     (queue_status),
        .queue_empty      (queue_empty),
        .next_up_ndown    (next_up_ndown),
        .pending_count    (pending_count),
        .req_error        (req_error),
        .door_open        (door_open)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] m_bits();
        logic [6:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_update();
        int cf = int'(current_floor);
        int rf = int'(req_floor);
        bit ab = 0, bl = 0, empty, err, door, ndir;
        int du = 100, dd = 100, nmode;
        if (reset) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_mode = 0; m_dir = 0; m_err = 0; m_door = 0; m_deq = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && i > cf) begin ab = 1; if (i - cf < du) du = i - cf; end
            if (m_pend[i] && i < cf) begin bl = 1; if (cf - i < dd) dd = cf - i; end
        end
        empty = (m_count() == 0);
        nmode = m_mode;
        if (m_mode == 1)      nmode = ab ? 1 : (bl ? 2 : 0);
        else if (m_mode == 2) nmode = bl ? 2 : (ab ? 1 : 0);
        else if (ab && bl)    nmode = (du < dd) ? 1 : ((dd < du) ? 2 : (current_up_ndown ? 1 : 2));
        else                  nmode = ab ? 1 : (bl ? 2 : 0);
        ndir = (m_mode == 1) ? 1'b1 : ((m_mode == 2) ? 1'b0 : m_dir);
        err  = req_valid && rf >= N;
        door = req_valid && rf < N && rf == cf && empty && m_mode == 0;
        if (deassert_floor && !m_deq && cf < N) m_pend[cf] = 0;
        if (req_valid && rf < N && !door) m_pend[rf] = 1;
        m_deq = deassert_floor; m_mode = nmode; m_dir = ndir; m_err = err; m_door = door;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; req_valid = 1'b0; deassert_floor = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_floor = 3'd3; current_floor = 3'd0;
        tick(); tick();
        total++; if (queue_status !== 7'd0) begin bad++; $display("FAIL reset_qs: got %b want 0000000", queue_status); end
        total++; if (queue_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", queue_empty); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", pending_count); end
        total++; if (next_up_ndown !== 1'b0) begin bad++; $display("FAIL reset_dir: got %b want 0", next_up_ndown); end
        total++; if ({req_error, door_open} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {req_error, door_open}); end
        reset = 1'b0; req_valid = 1'b0;
    endtask

    task automatic test_up_request();
        reset_dut();
        current_floor = 3'd2; req_valid = 1'b1; req_floor = 3'd5;
        tick();
        req_valid = 1'b0;
        total++; if (queue_status !== 7'b0100000) begin bad++; $display("FAIL up_qs: got %b want 0100000", queue_status); end
        total++; if (queue_empty !== 1'b0) begin bad++; $display("FAIL up_empty: got %b want 0", queue_empty); end
        total++; if (pending_count !== 3'd1) begin bad++; $display("FAIL up_count: got %0d want 1", pending_count); end
        tick();
        total++; if (next_up_ndown !== 1'b0) begin bad++; $display("FAIL up_dir_early: got %b want 0", next_up_ndown); end
        tick();
        total++; if (next_up_ndown !== 1'b1) begin bad++; $display("FAIL up_dir: got %b want 1", next_up_ndown); end
    endtask

    task automatic test_nearest();
        reset_dut();
        current_up_ndown = 1'b0; current_floor = 3'd0;
        req_valid = 1'b1; req_floor = 3'd1; tick();
        req_valid = 1'b0; tick();
        current_floor = 3'd1; tick();
        req_valid = 1'b1; req_floor = 3'd6; tick();
        req_valid = 1'b0; current_floor = 3'd3; tick();
        total++; if (next_up_ndown !== 1'b1) begin bad++; $display("FAIL near_dir_hold: got %b want 1", next_up_ndown); end
        tick();
        total++; if (next_up_ndown !== 1'b0) begin bad++; $display("FAIL near_dir_down: got %b want 0", next_up_ndown); end
        total++; if (queue_status !== 7'b1000010) begin bad++; $display("FAIL near_qs: got %b want 1000010", queue_status); end
        reset_dut();
        current_floor = 3'd2; req_valid = 1'b1; req_floor = 3'd1; tick();
        req_valid = 1'b0; tick();
        current_floor = 3'd1; tick();
        req_valid = 1'b1; req_floor = 3'd5; tick();
        req_valid = 1'b0; current_floor = 3'd3; current_up_ndown = 1'b1; tick();
        total++; if (next_up_ndown !== 1'b0) begin bad++; $display("FAIL tie_dir_hold: got %b want 0", next_up_ndown); end
        tick();
        total++; if (next_up_ndown !== 1'b1) begin bad++; $display("FAIL tie_dir_up: got %b want 1", next_up_ndown); end
        current_up_ndown = 1'b0;
    endtask

    task automatic test_deassert();
        reset_dut();
        current_floor = 3'd2; req_valid = 1'b1; req_floor = 3'd4; tick();
        req_valid = 1'b0; current_floor = 3'd4; tick();
        deassert_floor = 1'b1; tick();
        total++; if (queue_status !== 7'd0 || queue_empty !== 1'b1) begin bad++; $display("FAIL clr_once: got %b/%b want 0000000/1", queue_status, queue_empty); end
        tick();
        req_valid = 1'b1; req_floor = 3'd5; tick();
        req_valid = 1'b0; current_floor = 3'd5; tick(); tick();
        total++; if (queue_status !== 7'b0100000) begin bad++; $display("FAIL clr_held: got %b want 0100000", queue_status); end
        deassert_floor = 1'b0; tick();
        deassert_floor = 1'b1; req_valid = 1'b1; req_floor = 3'd5; tick();
        req_valid = 1'b0;
        total++; if (queue_status !== 7'b0100000) begin bad++; $display("FAIL set_wins: got %b want 0100000", queue_status); end
        tick();
        deassert_floor = 1'b0; tick();
        deassert_floor = 1'b1; tick();
        total++; if (queue_status !== 7'd0) begin bad++; $display("FAIL clr_again: got %b want 0000000", queue_status); end
        deassert_floor = 1'b0;
    endtask

    task automatic test_errors();
        reset_dut();
        current_floor = 3'd0; req_valid = 1'b1; req_floor = 3'd7; tick();
        req_valid = 1'b0;
        total++; if (req_error !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b want 1", req_error); end
        total++; if (queue_status !== 7'd0) begin bad++; $display("FAIL err_qs: got %b want 0000000", queue_status); end
        tick();
        total++; if (req_error !== 1'b0) begin bad++; $display("FAIL err_end: got %b want 0", req_error); end
        req_valid = 1'b1; req_floor = 3'd0; tick();
        req_valid = 1'b0;
        total++; if (door_open !== 1'b1 || queue_status !== 7'd0) begin bad++; $display("FAIL door_pulse: got %b/%b want 1/0000000", door_open, queue_status); end
        tick();
        total++; if (door_open !== 1'b0) begin bad++; $display("FAIL door_end: got %b want 0", door_open); end
    endtask

    task automatic test_reverse();
        reset_dut();
        current_floor = 3'd3; req_valid = 1'b1; req_floor = 3'd6; tick();
        req_floor = 3'd2; tick();
        req_valid = 1'b0; tick();
        total++; if (queue_status !== 7'b1000100 || next_up_ndown !== 1'b1) begin bad++; $display("FAIL rev_setup: got %b/%b want 1000100/1", queue_status, next_up_ndown); end
        current_floor = 3'd6; deassert_floor = 1'b1; tick();
        total++; if (queue_status !== 7'b0000100) begin bad++; $display("FAIL rev_clear: got %b want 0000100", queue_status); end
        deassert_floor = 1'b0; current_floor = 3'd3; tick();
        total++; if (next_up_ndown !== 1'b0) begin bad++; $display("FAIL rev_dir: got %b want 0", next_up_ndown); end
        req_valid = 1'b1; req_floor = 3'd2; tick();
        req_valid = 1'b0;
        total++; if (pending_count !== 3'd1 || req_error !== 1'b0) begin bad++; $display("FAIL dup_req: got %0d/%b want 1/0", pending_count, req_error); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        current_floor = 3'd2;
        req_valid = 1'b1; req_floor = 3'd3; tick();
        req_floor = 3'd0; tick();
        req_floor = 3'd6; tick();
        req_valid = 1'b0; tick();
        total++; if (queue_status !== 7'b1001001 || pending_count !== 3'd3 || next_up_ndown !== 1'b1) begin
            bad++; $display("FAIL mid_setup: got %b/%0d/%b want 1001001/3/1", queue_status, pending_count, next_up_ndown); end
        reset = 1'b1; tick();
        reset = 1'b0;
        total++; if (queue_status !== 7'd0 || queue_empty !== 1'b1 || next_up_ndown !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got %b/%b/%b want 0000000/1/0", queue_status, queue_empty, next_up_ndown); end
        tick();
        total++; if (next_up_ndown !== 1'b0 || queue_status !== 7'd0) begin bad++; $display("FAIL mid_idle: got %b/%b want 0/0000000", next_up_ndown, queue_status); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 59) == 0);
            req_valid = $urandom_range(0, 1);
            req_floor = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) current_floor = 3'($urandom_range(0, 7));
            current_up_ndown = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) deassert_floor = ~deassert_floor;
            tick();
            total++; if (queue_status !== m_bits()) begin bad++; $display("FAIL rnd_qs @%0d: got %b want %b", n, queue_status, m_bits()); end
            total++; if (queue_empty !== (m_count() == 0)) begin bad++; $display("FAIL rnd_empty @%0d: got %b want %b", n, queue_empty, m_count() == 0); end
            total++; if (int'(pending_count) != m_count()) begin bad++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, pending_count, m_count()); end
            total++; if (next_up_ndown !== m_dir) begin bad++; $display("FAIL rnd_dir @%0d: got %b want %b", n, next_up_ndown, m_dir); end
            total++; if (req_error !== m_err) begin bad++; $display("FAIL rnd_err @%0d: got %b want %b", n, req_error, m_err); end
            total++; if (door_open !== m_door) begin bad++; $display("FAIL rnd_door @%0d: got %b want %b", n, door_open, m_door); end
        end
        reset = 1'b0; req_valid = 1'b0; deassert_floor = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_request();
        test_nearest();
        test_deassert();
        test_errors();
        test_reverse();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
Collects floor requests from the hall and car call buttons and keeps the pending-floor bitmap that drives the elevator car model. It supplies the car's queue_status, queue_empty and next_up_ndown inputs and clears served floors when the car raises deassert_floor. Direction selection uses the LOOK policy: keep the current direction while requests remain ahead, reverse only when none remain.

Parameters:
NUM_FLOORS, 7, number of serviceable floors; valid floor indices are 0..NUM_FLOORS-1
FLOOR_W, 3, width of floor index buses
CNT_W, 3, width of pending_count; holds values 0..NUM_FLOORS

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request strobe; one request per cycle
req_floor  in  FLOOR_W  requested floor index
current_floor  in  FLOOR_W  car position, from the car model
current_up_ndown  in  1  car's committed direction, from the car model; used only for the tie-break
deassert_floor  in  1  level from the car; high while disembarking at current_floor
queue_status  out  NUM_FLOORS  pending bitmap; bit i = floor i pending
queue_empty  out  1  1 when queue_status == 0
next_up_ndown  out  1  recommended direction: 1 = up, 0 = down
pending_count  out  CNT_W  population count of queue_status
req_error  out  1  one-cycle pulse: request rejected
door_open  out  1  one-cycle pulse: request absorbed at the idle car's floor

Behaviour:
- Reset values:
  - pend = 0, so queue_status = 0, queue_empty = 1 and pending_count = 0.
  - FSM = IDLE, next_up_ndown = 0, req_error = 0, door_open = 0, deassert_q = 0.
  - Reset has priority over every other input.
  - Reset asserted mid-operation discards all pending requests within 1 cycle.
- State held: pend[NUM_FLOORS-1:0] register and deassert_q (deassert_floor delayed 1 cycle). All outputs are derived from registers.
- Request acceptance, evaluated on a cycle with req_valid = 1:
  - req_floor >= NUM_FLOORS: no state change; req_error = 1 on the next cycle.
  - req_floor == current_floor, queue_empty = 1 and FSM = IDLE: the bit is not set; door_open = 1 on the next cycle.
  - Otherwise: pend[req_floor] <= 1 and becomes visible on queue_status the next cycle (1-cycle latency).
  - A duplicate request leaves pend unchanged and raises no error.
- Service clear:
  - On the rising edge of deassert_floor (deassert_floor = 1, deassert_q = 0), pend[current_floor] <= 0.
  - A held-high deassert_floor clears only once.
  - current_floor >= NUM_FLOORS: no clear.
- Simultaneous set and clear of the same bit in one cycle: set wins and the bit stays 1 (re-request during disembark is kept).
- Derived signals, all from pend and current_floor:
  - above = |pend bits with index > current_floor.
  - below = |pend bits with index < current_floor.
  - current_floor >= NUM_FLOORS: every pending bit counts as below.
- FSM states: IDLE, UP, DOWN (2-bit encoding). It is evaluated every cycle from registered pend.
  - IDLE, above only -> UP.
  - IDLE, below only -> DOWN.
  - IDLE, both above and below -> go toward the floor at minimum |floor - current_floor|; on a distance tie, go in the direction of current_up_ndown.
  - IDLE, neither -> stay in IDLE.
  - UP: above -> stay UP; else below -> DOWN; else -> IDLE.
  - DOWN: below -> stay DOWN; else above -> UP; else -> IDLE.
- next_up_ndown:
  - Registered: 1 while in UP, 0 while in DOWN.
  - In IDLE it holds its last value.
  - Updates 1 cycle after the state transition.
- pending_count is the popcount of pend and saturates naturally at NUM_FLOORS; widths use unsigned arithmetic only.
- Distance math is unsigned, at FLOOR_W+1 bits.

Test Plan:
1. Reset, then req floor 5 with current_floor = 2 -> next cycle queue_status = 7'b0100000, queue_empty = 0, pending_count = 1; FSM = UP; next_up_ndown = 1 one cycle after the state change.
2. current_floor = 3, IDLE; requests 1 and 6 -> both above and below pending; nearest is floor 1 -> DOWN, next_up_ndown = 0. Repeat with requests 1 and 5 (a distance tie) and current_up_ndown = 1 -> UP.
3. pend = {4}, current_floor = 4; hold deassert_floor high for 5 cycles -> bit 4 clears exactly once, queue_empty = 1, FSM = IDLE. A request for 4 issued on the edge cycle keeps bit 4 = 1 (set wins).
4. req_floor = 7 -> req_error pulses for 1 cycle and queue_status is unchanged. req_floor = current_floor = 0 with an empty queue -> door_open pulses and queue_status stays 0.
5. UP with pend = {2, 6} and current_floor = 3; clear floor 6 -> FSM goes to DOWN and next_up_ndown falls to 0. Duplicate request 2 -> pending_count stays 1.
6. pend = {0, 3, 6}; assert reset for 1 cycle -> queue_status = 0, queue_empty = 1, FSM = IDLE, next_up_ndown = 0 on the cycle after reset.
